// File: rtl/demux_pkg.sv
// demux_pkg: shared state encoding and channel indices for the 1:4 stream demux and 4:1 mux
package demux_pkg;

    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

    localparam logic [1:0] CH_A = 2'd0;
    localparam logic [1:0] CH_B = 2'd1;
    localparam logic [1:0] CH_C = 2'd2;
    localparam logic [1:0] CH_D = 2'd3;

    function automatic logic [3:0] ch_onehot(input logic [1:0] sel);
        return 4'b0001 << sel;
    endfunction

endpackage

// File: rtl/sat_wrap_counter.sv
// sat_wrap_counter: CW-bit enable counter that wraps to zero, async active-high reset
module sat_wrap_counter #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [CW-1:0] q
);

    // count one per enabled cycle, natural modulo-2^CW wrap
    always_ff @(posedge clk or posedge rst)
        if (rst)
            q <= '0;
        else if (en)
            q <= q + 1'b1;

endmodule

// File: rtl/demux4_stream.sv
// demux4_stream: one-slot registered 1:4 stream demux with per-channel delivery counters
module demux4_stream
    import demux_pkg::*;
#(
    parameter int W  = 8,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic          s1,
    input  logic          s0,
    output logic          a_valid,
    output logic          b_valid,
    output logic          c_valid,
    output logic          d_valid,
    input  logic          a_ready,
    input  logic          b_ready,
    input  logic          c_ready,
    input  logic          d_ready,
    output logic [W-1:0]  a_data,
    output logic [W-1:0]  b_data,
    output logic [W-1:0]  c_data,
    output logic [W-1:0]  d_data,
    output logic [CW-1:0] cnt_a,
    output logic [CW-1:0] cnt_b,
    output logic [CW-1:0] cnt_c,
    output logic [CW-1:0] cnt_d
);

    logic         st;
    logic [W-1:0] slot_data;
    logic [1:0]   slot_sel;
    logic [3:0]   rdy;
    logic [3:0]   vld;
    logic         drain;
    logic         accept;

    // drain needs a full slot and the addressed consumer; ready on other channels is ignored
    always_comb begin
        rdy      = {d_ready, c_ready, b_ready, a_ready};
        vld      = (st == ST_FULL) ? ch_onehot(slot_sel) : 4'b0000;
        drain    = (st == ST_FULL) & rdy[slot_sel];
        in_ready = (st == ST_EMPTY) | rdy[slot_sel];
        accept   = in_valid & in_ready;
    end

    // channel outputs decode from registered state only; idle channels read zero
    always_comb begin
        {d_valid, c_valid, b_valid, a_valid} = vld;
        a_data = vld[CH_A] ? slot_data : '0;
        b_data = vld[CH_B] ? slot_data : '0;
        c_data = vld[CH_C] ? slot_data : '0;
        d_data = vld[CH_D] ? slot_data : '0;
    end

    // slot fills on accept (overwriting in the drain cycle), empties on a lone drain, else holds
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            st        <= ST_EMPTY;
            slot_data <= '0;
            slot_sel  <= CH_A;
        end else if (accept) begin
            st        <= ST_FULL;
            slot_data <= in_data;
            slot_sel  <= {s1, s0};
        end else if (drain) begin
            st        <= ST_EMPTY;
        end

    sat_wrap_counter #(.CW(CW)) u_cnt_a (
        .clk (clk),
        .rst (rst),
        .en  (drain & (slot_sel == CH_A)),
        .q   (cnt_a)
    );

    sat_wrap_counter #(.CW(CW)) u_cnt_b (
        .clk (clk),
        .rst (rst),
        .en  (drain & (slot_sel == CH_B)),
        .q   (cnt_b)
    );

    sat_wrap_counter #(.CW(CW)) u_cnt_c (
        .clk (clk),
        .rst (rst),
        .en  (drain & (slot_sel == CH_C)),
        .q   (cnt_c)
    );

    sat_wrap_counter #(.CW(CW)) u_cnt_d (
        .clk (clk),
        .rst (rst),
        .en  (drain & (slot_sel == CH_D)),
        .q   (cnt_d)
    );

endmodule
